// File: rtl/fft_frame_sequencer_if.sv
// rtl/fft_frame_sequencer_if.sv - sample stream, FFT core and result stream bundle for fft_frame_sequencer
interface fft_frame_sequencer_if #(
    parameter int WORD_SIZE = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [WORD_SIZE-1:0]      in_re;
    logic [WORD_SIZE-1:0]      in_im;
    logic                      core_start;
    logic                      core_done;
    logic [16*WORD_SIZE-1:0]   frame_re;
    logic [16*WORD_SIZE-1:0]   frame_im;
    logic [16*WORD_SIZE-1:0]   res_re;
    logic [16*WORD_SIZE-1:0]   res_im;
    logic                      out_valid;
    logic                      out_ready;
    logic [WORD_SIZE-1:0]      out_re;
    logic [WORD_SIZE-1:0]      out_im;
    logic                      out_last;
    logic                      err;

    modport slave (
        input  in_valid, in_re, in_im, core_done, res_re, res_im, out_ready,
        output in_ready, core_start, frame_re, frame_im, out_valid, out_re, out_im, out_last, err
    );

    modport master (
        output in_valid, in_re, in_im, core_done, res_re, res_im, out_ready,
        input  in_ready, core_start, frame_re, frame_im, out_valid, out_re, out_im, out_last, err
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - gathers 16-sample frames, launches the FFT core, streams results back out
// Optional WAIT watchdog compiled in with macro FFT_WDOG_EN.
module fft_frame_sequencer #(
    parameter int WORD_SIZE   = 16,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_frame_sequencer_if.slave bus
);
    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_wr_idx;
    logic [3:0]              r_rd_idx;
    logic [16*WORD_SIZE-1:0] r_frame_re;
    logic [16*WORD_SIZE-1:0] r_frame_im;
    logic [16*WORD_SIZE-1:0] r_res_re;
    logic [16*WORD_SIZE-1:0] r_res_im;
    logic                    w_in_ready;
    logic                    w_core_start;
    logic                    w_out_valid;
    logic                    w_capture;
    logic                    w_timeout;
    logic                    w_in_fire;
    logic                    w_out_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_core_start = 1'b0;
        w_out_valid  = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && r_wr_idx == 4'd15) begin
                    w_next_state = START;
                end
            end
            START: begin
                w_core_start = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                // a done arriving on the timeout cycle still wins
                if (bus.core_done) begin
                    w_capture    = 1'b1;
                    w_next_state = UNLOAD;
                end else if (w_timeout) begin
                    w_next_state = LOAD;
                end
            end
            UNLOAD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready && r_rd_idx == 4'd15) begin
                    w_next_state = LOAD;
                end
            end
            default: w_next_state = LOAD;
        endcase
    end

    assign w_in_fire  = w_in_ready && bus.in_valid;
    assign w_out_fire = w_out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx   <= 4'd0;
            r_rd_idx   <= 4'd0;
            r_frame_re <= '0;
            r_frame_im <= '0;
            r_res_re   <= '0;
            r_res_im   <= '0;
        end else begin
            if (w_in_fire) begin
                r_frame_re[r_wr_idx*WORD_SIZE +: WORD_SIZE] <= bus.in_re;
                r_frame_im[r_wr_idx*WORD_SIZE +: WORD_SIZE] <= bus.in_im;
                r_wr_idx <= r_wr_idx + 4'd1;
            end
            if (w_capture) begin
                r_res_re <= bus.res_re;
                r_res_im <= bus.res_im;
            end
            if (w_out_fire) begin
                r_rd_idx <= r_rd_idx + 4'd1;
            end
        end
    end

`ifdef FFT_WDOG_EN
    logic [15:0] r_wdog;
    logic        r_err;

    assign w_timeout = (r_state == WAIT) && !bus.core_done &&
                       (r_wdog == 16'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= 16'd0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == START) begin
                r_wdog <= 16'd0;
            end else if (r_state == WAIT && !bus.core_done && !w_timeout) begin
                r_wdog <= r_wdog + 16'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.err = r_err;
`else
    logic w_unused_wdog;

    assign w_unused_wdog = (WDOG_CYCLES != 0);
    assign w_timeout     = 1'b0;
    assign bus.err       = 1'b0;
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.core_start = w_core_start;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_last   = w_out_valid && (r_rd_idx == 4'd15);
    assign bus.out_re     = r_res_re[r_rd_idx*WORD_SIZE +: WORD_SIZE];
    assign bus.out_im     = r_res_im[r_rd_idx*WORD_SIZE +: WORD_SIZE];
    assign bus.frame_re   = r_frame_re;
    assign bus.frame_im   = r_frame_im;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - directed self-checking bench for fft_frame_sequencer
module tb_fft_frame_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.WORD_SIZE(16)) bus ();

    fft_frame_sequencer #(.WORD_SIZE(16), .WDOG_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_res(input int re_base, input int im_base);
        for (int k = 0; k < 16; k++) begin
            bus.res_re[k*16 +: 16] = 16'(re_base + k);
            bus.res_im[k*16 +: 16] = 16'(im_base + k);
        end
    endtask

    // returns at the negedge of the first WAIT cycle
    task automatic load_frame(input int base, input bit pulse_done);
        for (int k = 0; k < 16; k++) begin
            bus.in_valid  = 1'b1;
            bus.in_re     = 16'(base + k);
            bus.in_im     = 16'(-(base + k));
            bus.core_done = pulse_done && (k == 3);
            if (pulse_done && k == 3) set_res(16'h7777, 16'h7777);
            check_eq("in_ready_load", 64'(bus.in_ready), 64'd1);
            check_eq("core_start_load", 64'(bus.core_start), 64'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.core_done = 1'b0;
        check_eq("in_ready_drop", 64'(bus.in_ready), 64'd0);
        check_eq("core_start_pulse", 64'(bus.core_start), 64'd1);
        check_eq("out_valid_start", 64'(bus.out_valid), 64'd0);
        tick();
        check_eq("core_start_single", 64'(bus.core_start), 64'd0);
        check_eq("in_ready_wait", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic unload(input int re_base, input int im_base, input bit toggle, input bit pulse_done);
        int beats = 0;
        int cyc   = 0;
        while (beats < 16 && cyc < 80) begin
            bus.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.core_done = pulse_done && (cyc == 4);
            if (pulse_done && cyc == 4) set_res(16'h1234, 16'h1234);
            if (bus.out_valid) begin
                check_eq("out_re", 64'(bus.out_re), 64'(16'(re_base + beats)));
                check_eq("out_im", 64'(bus.out_im), 64'(16'(im_base + beats)));
                check_eq("out_last", 64'(bus.out_last), 64'(beats == 15));
                check_eq("in_ready_unload", 64'(bus.in_ready), 64'd0);
                if (bus.out_ready) beats++;
            end else begin
                check_eq("out_valid_unload", 64'(bus.out_valid), 64'd1);
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.core_done = 1'b0;
        check_eq("unload_beats", 64'(beats), 64'd16);
        check_eq("out_valid_after", 64'(bus.out_valid), 64'd0);
        check_eq("out_last_after", 64'(bus.out_last), 64'd0);
        check_eq("in_ready_after", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.core_done = 1'b0;
        bus.res_re    = '0;
        bus.res_im    = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_core_start", 64'(bus.core_start), 64'd0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_last", 64'(bus.out_last), 64'd0);
        check_eq("rst_err", 64'(bus.err), 64'd0);
        check_eq("rst_frame_re", 64'(bus.frame_re[15:0]), 64'd0);
        check_eq("rst_out_re", 64'(bus.out_re), 64'd0);

        // frame 1: ramp in, done 5 cycles after start, free-flowing output
        load_frame(0, 1'b0);
        check_eq("frame_re_s5", 64'(bus.frame_re[5*16 +: 16]), 64'h0005);
        check_eq("frame_im_s5", 64'(bus.frame_im[5*16 +: 16]), 64'hFFFB);
        check_eq("frame_re_s15", 64'(bus.frame_re[15*16 +: 16]), 64'h000F);
        set_res(100, 200);
        for (int i = 0; i < 4; i++) begin
            check_eq("out_valid_wait", 64'(bus.out_valid), 64'd0);
            tick();
        end
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        check_eq("done_latency", 64'(bus.out_valid), 64'd1);
        check_eq("frame_re_hold", 64'(bus.frame_re[5*16 +: 16]), 64'h0005);
        unload(100, 200, 1'b0, 1'b0);

        // frame 2: stray core_done in LOAD and UNLOAD, stalled output
        load_frame(40, 1'b1);
        check_eq("frame2_re_s15", 64'(bus.frame_re[15*16 +: 16]), 64'd55);
        set_res(300, 400);
        tick();
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        unload(300, 400, 1'b1, 1'b1);

        // reset mid-load discards the partial frame
        for (int k = 0; k < 7; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re    = 16'(50 + k);
            bus.in_im    = 16'(50 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("midrst_frame_re", 64'(bus.frame_re[0 +: 16]), 64'd0);
        tick();
        check_eq("midrst_no_start", 64'(bus.core_start), 64'd0);
        load_frame(20, 1'b0);
        check_eq("fresh_s0", 64'(bus.frame_re[0 +: 16]), 64'd20);
        check_eq("fresh_s6", 64'(bus.frame_re[6*16 +: 16]), 64'd26);

`ifdef FFT_WDOG_EN
        for (int i = 0; i < 7; i++) tick();
        check_eq("wdog_err_pre", 64'(bus.err), 64'd0);
        check_eq("wdog_in_ready_pre", 64'(bus.in_ready), 64'd0);
        tick();
        check_eq("wdog_err_set", 64'(bus.err), 64'd1);
        check_eq("wdog_back_load", 64'(bus.in_ready), 64'd1);
        bus.core_done = 1'b1;
        tick();
        bus.core_done = 1'b0;
        check_eq("wdog_done_ignored", 64'(bus.out_valid), 64'd0);
        check_eq("wdog_err_sticky", 64'(bus.err), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("wdog_err_clear", 64'(bus.err), 64'd0);
`else
        for (int i = 0; i < 20; i++) tick();
        check_eq("wait_persist", 64'(bus.in_ready), 64'd0);
        check_eq("wait_no_out", 64'(bus.out_valid), 64'd0);
        check_eq("err_const", 64'(bus.err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
